nbody_step_ctrl: RTL and testbench
==================================

# nbody_step_ctrl

Parametrised step sequencer for the n-body accelerator. It owns the pairwise-acceleration and position-update schedule for one or more leapfrog steps. It issues body-pair read addresses, with LANES j-bodies per cycle, to the acceleration pipeline, and tracks in-flight tags through a latency-matched delay line. It then issues position-update reads and writes, repeats for a programmed step count, and completes with a start/done handshake toward the bus-facing register block.

## Interface
Parameters:
- BODIES, 512, maximum body count
- BODY_ADDR_WIDTH, $clog2(BODIES), body index width
- LANES, 1, j-bodies issued per cycle (power of two, 1..8)
- ACCL_LATENCY, 100, cycles from pair issue to acceleration result (≥1)
- ADD_LATENCY, 20, cycles from position read to position write (≥1)
- STEP_WIDTH, 16, step counter width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock
  - rst  in  1  asynchronous active-high reset
- Command and status:
  - start  in  1  start pulse; sampled only in IDLE
  - abort  in  1  synchronous abort, any state
  - num_bodies  in  BODY_ADDR_WIDTH+1  body count n; sampled at start
  - num_steps  in  STEP_WIDTH  step count S; sampled at start
  - busy  out  1  high in any state other than IDLE
  - done  out  1  level; set on completion, cleared on accepted start or abort
  - step_idx  out  STEP_WIDTH  current step index
  - first_step  out  1  high while step_idx==0 and busy (drives half-kick)
- Pair issue:
  - issue_valid  out  1  pair group issued this cycle
  - issue_i  out  BODY_ADDR_WIDTH  i body
  - issue_j  out  BODY_ADDR_WIDTH  j base, multiple of LANES
  - issue_mask  out  LANES  lane l valid iff issue_j+l < n
- Acceleration result:
  - acc_valid  out  1  issue_valid delayed ACCL_LATENCY cycles
  - acc_i  out  BODY_ADDR_WIDTH  delayed issue_i
  - acc_mask  out  LANES  delayed issue_mask
  - acc_last  out  1  delayed flag marking the last j group of row i; velocity commit strobe
- Position update:
  - pos_rd_valid  out  1  position read
  - pos_rd_addr  out  BODY_ADDR_WIDTH  position read address
  - pos_wr_valid  out  1  pos_rd_valid delayed ADD_LATENCY cycles
  - pos_wr_addr  out  BODY_ADDR_WIDTH  delayed pos_rd_addr

## Operation
- States are IDLE → ISSUE → DRAIN → POS → (ISSUE | IDLE).
- **IDLE.**
  - start with n≥2 and S≥1: latch n and S, clear done, step_idx=0, go to ISSUE.
  - start with n<2 or S==0: no issues, done=1 the next cycle, stay IDLE.
  - n>BODIES is clamped to BODIES.
- **ISSUE.**
  - G = ceil(n/LANES) groups per row.
  - Iterate i=0..n-1 (outer) and j=0,LANES,…,(G-1)·LANES (inner); one group per cycle, issue_valid=1.
  - The self-pair i==j is issued; the datapath masks it.
  - The last j group of each row carries the last flag.
  - After the final group, go to DRAIN.
- **DRAIN.**
  - Lasts exactly ACCL_LATENCY cycles, counted from the cycle after the last issue. It ends on the cycle the last acc_valid appears.
  - Then go to POS.
- **POS.**
  - Issue pos_rd for k=0..n-1, one per cycle.
  - Stay in POS until the last pos_wr_valid.
  - Next cycle: if step_idx==S-1, set done and go to IDLE. Otherwise increment step_idx and go to ISSUE.
- **Delay lines.**
  - Two shift-register delay lines, one per latency, carry valid plus tags.
  - They shift every cycle regardless of state.
- **abort.**
  - Next cycle: state is IDLE, both delay lines are flushed (all valids 0), done=0, busy=0.
  - abort has priority over a simultaneous start.
- **Reset.** Every output is 0, state is IDLE, delay lines are cleared. Reset mid-step discards all in-flight tags.

## Timing
- Cycle 0 is the cycle start is sampled.
- Step k, with P = n·G + ACCL_LATENCY + n + ADD_LATENCY:
  - Issues occupy cycles 1+kP … kP+n·G.
  - acc_valid occupies those cycles +ACCL_LATENCY.
  - pos_rd occupies kP+n·G+ACCL_LATENCY+1 … kP+n·G+ACCL_LATENCY+n.
  - pos_wr occupies pos_rd +ADD_LATENCY.
- done rises at cycle S·P+1; busy falls in the same cycle.
- No bubbles inside ISSUE or POS; issue_valid is contiguous per step.
- Index counters wrap to 0 at the row end. step_idx never wraps, because the run terminates at S-1.

## Test plan
- **Single step.** n=4, LANES=1, ACCL_LATENCY=8, ADD_LATENCY=3, S=1 → issue_valid cycles 1–16 with (i,j) = (0,0)…(3,3); acc_last at cycles 12, 16, 20, 24; pos_rd cycles 25–28, addr 0–3; pos_wr cycles 28–31; done=1 at cycle 32.
- **Two steps.** Same configuration, S=2 → second issue burst starts at cycle 32 with step_idx=1 and first_step=0; done at cycle 63.
- **Partial lane mask.** LANES=4, n=6 → groups j=0 mask 1111, then j=4 mask 0011; 12 issues per step; acc_last on every j=4 group.
- **Degenerate start.** start with n=1, then with S=0 → no issue_valid or pos_rd; done=1 the cycle after start.
- **Abort.** abort during DRAIN of step 0 → next cycle busy=0, done=0, and no acc_valid or pos_wr afterwards. A start issued later runs the full schedule correctly.
- **Reset mid-run.** Assert rst asynchronously in mid-ISSUE → all outputs 0 immediately; after release, a start runs cleanly and start is ignored while busy.

Source files
------------

// File: rtl/nbody_step_ctrl.sv
// Leapfrog step sequencer for the n-body accelerator: pair issue, acceleration drain,
// position update, repeated for a programmed step count with a start/done handshake.
module nbody_step_ctrl #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int LANES           = 1,
  parameter int ACCL_LATENCY    = 100,
  parameter int ADD_LATENCY     = 20,
  parameter int STEP_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
  input  logic [STEP_WIDTH-1:0]      num_steps,
  output logic                       busy,
  output logic                       done,
  output logic [STEP_WIDTH-1:0]      step_idx,
  output logic                       first_step,
  output logic                       issue_valid,
  output logic [BODY_ADDR_WIDTH-1:0] issue_i,
  output logic [BODY_ADDR_WIDTH-1:0] issue_j,
  output logic [LANES-1:0]           issue_mask,
  output logic                       acc_valid,
  output logic [BODY_ADDR_WIDTH-1:0] acc_i,
  output logic [LANES-1:0]           acc_mask,
  output logic                       acc_last,
  output logic                       pos_rd_valid,
  output logic [BODY_ADDR_WIDTH-1:0] pos_rd_addr,
  output logic                       pos_wr_valid,
  output logic [BODY_ADDR_WIDTH-1:0] pos_wr_addr
);

  localparam int NW = BODY_ADDR_WIDTH + 1;
  localparam int CW = $clog2(ACCL_LATENCY + ADD_LATENCY + BODIES + 2) + 1;
  localparam int TW = BODY_ADDR_WIDTH + LANES + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, POS} state_t;
  state_t state, state_nxt;

  logic [NW-1:0]              n_q;
  logic [STEP_WIDTH-1:0]      s_q;
  logic [STEP_WIDTH-1:0]      step_q;
  logic [BODY_ADDR_WIDTH-1:0] i_q;
  logic [NW-1:0]              j_q;
  logic [CW-1:0]              cnt_q;
  logic                       done_q;

  logic [NW-1:0] n_clamp;
  logic          start_ok;
  logic          row_last;
  logic          issue_end;
  logic          drain_end;
  logic          pos_end;
  logic          last_step;

  logic          acc_vld_p  [ACCL_LATENCY];
  logic [TW-1:0] acc_tag_p  [ACCL_LATENCY];
  logic          pos_vld_p  [ADD_LATENCY];
  logic [BODY_ADDR_WIDTH-1:0] pos_addr_p [ADD_LATENCY];

  assign n_clamp   = (num_bodies > NW'(BODIES)) ? NW'(BODIES) : num_bodies;
  assign start_ok  = (n_clamp >= NW'(2)) && (num_steps != '0);
  assign row_last  = ({1'b0, j_q} + (NW+1)'(LANES)) >= {1'b0, n_q};
  assign issue_end = row_last && (i_q == BODY_ADDR_WIDTH'(n_q - NW'(1)));
  assign drain_end = cnt_q == CW'(ACCL_LATENCY - 1);
  assign pos_end   = (cnt_q + CW'(1)) == (CW'(n_q) + CW'(ADD_LATENCY));
  assign last_step = step_q == (s_q - STEP_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (start && start_ok) state_nxt = ISSUE;
        ISSUE: if (issue_end)         state_nxt = DRAIN;
        DRAIN: if (drain_end)         state_nxt = POS;
        POS:   if (pos_end)           state_nxt = last_step ? IDLE : ISSUE;
        default:                      state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = state != IDLE;
    issue_valid  = state == ISSUE;
    issue_i      = issue_valid ? i_q : '0;
    issue_j      = issue_valid ? j_q[BODY_ADDR_WIDTH-1:0] : '0;
    for (int l = 0; l < LANES; l++)
      issue_mask[l] = issue_valid && (({1'b0, j_q} + (NW+1)'(l)) < {1'b0, n_q});
    pos_rd_valid = (state == POS) && (cnt_q < CW'(n_q));
    pos_rd_addr  = pos_rd_valid ? BODY_ADDR_WIDTH'(cnt_q) : '0;
  end

  // Counters: i/j walk the pair grid, cnt times DRAIN and POS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q    <= '0;
      s_q    <= '0;
      step_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (abort) begin
      step_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && start_ok) begin
            n_q    <= n_clamp;
            s_q    <= num_steps;
            step_q <= '0;
            i_q    <= '0;
            j_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
          end else if (start) begin
            done_q <= 1'b1;
          end
        end
        ISSUE: begin
          cnt_q <= '0;
          if (row_last) begin
            j_q <= '0;
            i_q <= issue_end ? '0 : i_q + BODY_ADDR_WIDTH'(1);
          end else begin
            j_q <= j_q + NW'(LANES);
          end
        end
        DRAIN: cnt_q <= drain_end ? '0 : cnt_q + CW'(1);
        POS: begin
          if (pos_end) begin
            cnt_q <= '0;
            if (last_step) done_q <= 1'b1;
            else           step_q <= step_q + STEP_WIDTH'(1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Latency-matched delay lines; abort flushes valids, tags keep shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ACCL_LATENCY; k++) begin
        acc_vld_p[k] <= 1'b0;
        acc_tag_p[k] <= '0;
      end
      for (int k = 0; k < ADD_LATENCY; k++) begin
        pos_vld_p[k]  <= 1'b0;
        pos_addr_p[k] <= '0;
      end
    end else begin
      acc_vld_p[0] <= issue_valid && !abort;
      acc_tag_p[0] <= {issue_valid && row_last, issue_mask, issue_i};
      for (int k = 1; k < ACCL_LATENCY; k++) begin
        acc_vld_p[k] <= acc_vld_p[k-1] && !abort;
        acc_tag_p[k] <= acc_tag_p[k-1];
      end
      pos_vld_p[0]  <= pos_rd_valid && !abort;
      pos_addr_p[0] <= pos_rd_addr;
      for (int k = 1; k < ADD_LATENCY; k++) begin
        pos_vld_p[k]  <= pos_vld_p[k-1] && !abort;
        pos_addr_p[k] <= pos_addr_p[k-1];
      end
    end
  end

  assign acc_valid    = acc_vld_p[ACCL_LATENCY-1];
  assign acc_i        = acc_tag_p[ACCL_LATENCY-1][BODY_ADDR_WIDTH-1:0];
  assign acc_mask     = acc_tag_p[ACCL_LATENCY-1][BODY_ADDR_WIDTH +: LANES];
  assign acc_last     = acc_tag_p[ACCL_LATENCY-1][TW-1];
  assign pos_wr_valid = pos_vld_p[ADD_LATENCY-1];
  assign pos_wr_addr  = pos_addr_p[ADD_LATENCY-1];
  assign done         = done_q;
  assign step_idx     = step_q;
  assign first_step   = busy && (step_q == '0);

endmodule

// File: tb/tb_nbody_step_ctrl.sv
// Directed bench for nbody_step_ctrl: one LANES=1 and one LANES=4 instance, cycle masks
// of every strobe compared against hand-derived schedules.
module tb_nbody_step_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start1 = 1'b0, start4 = 1'b0, abort = 1'b0;
  logic [4:0]  nb = '0;
  logic [15:0] ns = '0;

  logic busy1, done1, fs1, iv1, av1, al1, pr1, pw1;
  logic [15:0] step1;
  logic [3:0] ii1, ij1, ai1, pra1, pwa1;
  logic [0:0] im1, am1;

  logic busy4, done4, fs4, iv4, av4, al4, pr4, pw4;
  logic [15:0] step4;
  logic [3:0] ii4, ij4, ai4, pra4, pwa4, im4, am4;

  nbody_step_ctrl #(.BODIES(16), .LANES(1), .ACCL_LATENCY(8), .ADD_LATENCY(3), .STEP_WIDTH(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .num_bodies(nb), .num_steps(ns),
    .busy(busy1), .done(done1), .step_idx(step1), .first_step(fs1),
    .issue_valid(iv1), .issue_i(ii1), .issue_j(ij1), .issue_mask(im1),
    .acc_valid(av1), .acc_i(ai1), .acc_mask(am1), .acc_last(al1),
    .pos_rd_valid(pr1), .pos_rd_addr(pra1), .pos_wr_valid(pw1), .pos_wr_addr(pwa1));

  nbody_step_ctrl #(.BODIES(16), .LANES(4), .ACCL_LATENCY(8), .ADD_LATENCY(3), .STEP_WIDTH(16)) u4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort), .num_bodies(nb), .num_steps(ns),
    .busy(busy4), .done(done4), .step_idx(step4), .first_step(fs4),
    .issue_valid(iv4), .issue_i(ii4), .issue_j(ij4), .issue_mask(im4),
    .acc_valid(av4), .acc_i(ai4), .acc_mask(am4), .acc_last(al4),
    .pos_rd_valid(pr4), .pos_rd_addr(pra4), .pos_wr_valid(pw4), .pos_wr_addr(pwa4));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [127:0] m_iv, m_av, m_al, m_pr, m_pw, m_done, m_busy, m_fs;
  int seq_err;
  int st_at32;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rng(input int a, input int b);
    logic [127:0] m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic do_start1(input int n, input int s);
    @(negedge clk);
    nb = 5'(n); ns = 16'(s); start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic do_start4(input int n, input int s);
    @(negedge clk);
    nb = 5'(n); ns = 16'(s); start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  // Samples u1 from cycle 1 (first cycle after the start edge) through ncyc.
  task automatic mon1(input int ncyc, input int n, input int restart_at);
    int k = 0, a = 0, p = 0, w = 0;
    m_iv = '0; m_av = '0; m_al = '0; m_pr = '0; m_pw = '0; m_done = '0; m_busy = '0; m_fs = '0;
    seq_err = 0; st_at32 = -1;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == restart_at) begin nb = 5'd2; start1 = 1'b1; end
      else start1 = 1'b0;
      if (iv1) begin
        m_iv[c] = 1'b1;
        if (ii1 != 4'(k / n) || ij1 != 4'(k % n) || im1 != 1'b1) seq_err++;
        k = (k + 1) % (n * n);
      end
      if (av1) begin
        m_av[c] = 1'b1;
        if (ai1 != 4'(a / n)) seq_err++;
        a = (a + 1) % (n * n);
      end
      if (al1)   m_al[c] = 1'b1;
      if (pr1) begin m_pr[c] = 1'b1; if (pra1 != 4'(p)) seq_err++; p = (p + 1) % n; end
      if (pw1) begin m_pw[c] = 1'b1; if (pwa1 != 4'(w)) seq_err++; w = (w + 1) % n; end
      if (done1) m_done[c] = 1'b1;
      if (busy1) m_busy[c] = 1'b1;
      if (fs1)   m_fs[c] = 1'b1;
      if (c == 32) st_at32 = int'(step1);
      if (c < ncyc) @(negedge clk);
    end
    start1 = 1'b0;
  endtask

  task automatic expect_single(input string p);
    check({p, "_issue"}, m_iv, rng(1, 16));
    check({p, "_acc"},   m_av, rng(9, 24));
    check({p, "_last"},  m_al, rng(12, 12) | rng(16, 16) | rng(20, 20) | rng(24, 24));
    check({p, "_posrd"}, m_pr, rng(25, 28));
    check({p, "_poswr"}, m_pw, rng(28, 31));
    check({p, "_done"},  m_done, rng(32, 40));
    check({p, "_busy"},  m_busy, rng(1, 31));
    check({p, "_first"}, m_fs, rng(1, 31));
    check({p, "_seq"},   128'(seq_err), 128'(0));
  endtask

  initial begin
    int k;
    logic [127:0] mm;
    #1 rst = 1'b1;
    #2;
    check("rst_outputs_async", {iv1, busy1, done1, av1, al1, pr1, pw1, fs1, step1, ii1, ij1, ai1, pra1, pwa1,
                                iv4, busy4, done4, av4, pw4, im4, am4}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs_idle", {iv1, busy1, done1, av1, pr1, pw1, fs1, step1, iv4, busy4, done4}, '0);

    // Single step, n=4
    do_start1(4, 1);
    mon1(40, 4, 0);
    expect_single("single");

    // Two steps
    do_start1(4, 2);
    mon1(70, 4, 0);
    check("two_issue", m_iv, rng(1, 16) | rng(32, 47));
    check("two_acc",   m_av, rng(9, 24) | rng(40, 55));
    check("two_posrd", m_pr, rng(25, 28) | rng(56, 59));
    check("two_poswr", m_pw, rng(28, 31) | rng(59, 62));
    check("two_done",  m_done, rng(63, 70));
    check("two_busy",  m_busy, rng(1, 62));
    check("two_first", m_fs, rng(1, 31));
    check("two_step1", 128'(st_at32), 128'(1));
    check("two_seq",   128'(seq_err), 128'(0));

    // Partial lane mask, LANES=4, n=6
    do_start4(6, 1);
    m_iv = '0; m_al = '0; m_av = '0; m_pr = '0; m_pw = '0; m_done = '0; seq_err = 0; k = 0;
    begin
      int a = 0;
      for (int c = 1; c <= 34; c++) begin
        if (iv4) begin
          m_iv[c] = 1'b1;
          if (ii4 != 4'(k / 2) || ij4 != ((k % 2 == 1) ? 4'd4 : 4'd0) ||
              im4 != ((k % 2 == 1) ? 4'b0011 : 4'b1111)) seq_err++;
          k++;
        end
        if (av4) begin
          m_av[c] = 1'b1;
          if (am4 != ((a % 2 == 1) ? 4'b0011 : 4'b1111) || ai4 != 4'(a / 2)) seq_err++;
          a++;
        end
        if (al4)   m_al[c] = 1'b1;
        if (pr4)   m_pr[c] = 1'b1;
        if (pw4)   m_pw[c] = 1'b1;
        if (done4) m_done[c] = 1'b1;
        if (c < 34) @(negedge clk);
      end
    end
    mm = '0;
    for (int c = 10; c <= 20; c += 2) mm[c] = 1'b1;
    check("lanes_issue", m_iv, rng(1, 12));
    check("lanes_acc",   m_av, rng(9, 20));
    check("lanes_last",  m_al, mm);
    check("lanes_posrd", m_pr, rng(21, 26));
    check("lanes_poswr", m_pw, rng(24, 29));
    check("lanes_done",  m_done, rng(30, 34));
    check("lanes_seq",   128'(seq_err), 128'(0));

    // Degenerate starts
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_clears_done", 128'(done1), 128'(0));
    do_start1(1, 3);
    mon1(5, 1, 0);
    check("n1_issue", m_iv | m_pr | m_busy, '0);
    check("n1_done",  m_done, rng(1, 5));
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    do_start1(4, 0);
    mon1(5, 4, 0);
    check("s0_issue", m_iv | m_pr | m_busy, '0);
    check("s0_done",  m_done, rng(1, 5));

    // Abort during DRAIN of step 0
    do_start1(4, 1);
    repeat (19) @(negedge clk);
    check("abort_pre_busy", {busy1, iv1, av1}, 128'(3'b101));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_next", {busy1, done1, av1, pr1}, '0);
    mm = '0;
    for (int c = 0; c < 30; c++) begin
      if (av1 || pw1 || pr1 || iv1) mm[c] = 1'b1;
      @(negedge clk);
    end
    check("abort_quiet", mm, '0);
    do_start1(4, 1);
    mon1(40, 4, 0);
    expect_single("abort_rerun");

    // Asynchronous reset mid-ISSUE
    do_start1(4, 1);
    repeat (4) @(negedge clk);
    check("rst_pre_issue", 128'(iv1), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {iv1, busy1, done1, av1, al1, pr1, pw1, fs1, step1, ii1, ij1, ai1, pra1, pwa1}, '0);
    @(negedge clk);
    rst = 1'b0;
    do_start1(4, 1);
    mon1(40, 4, 10);
    expect_single("rst_rerun");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
